// File: rtl/data_memory_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package data_memory_responder_pkg;

  // Request life cycle: idle, counting down the latency, then the ack cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES      = 4;
  localparam int DEFAULT_DEPTH   = 1024;
  localparam int DEFAULT_LATENCY = 10;

endpackage

// File: rtl/data_memory_responder_latency_counter.sv
// Loadable down-counter with a zero flag; it counts the wait edges of a request.
module latency_counter #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Load has priority over decrement; decrementing stops at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory responder on the CPU load/store port.
// One request at a time, fixed programmable latency, word-addressed storage.
// Optional macro DATA_MEMORY_RESPONDER_RANGE_CHECK_EN flags out-of-range or
// misaligned addresses: such requests complete normally but do not write,
// loads return zero and err_o is raised for the ack cycle.
//
// Handshake: the requester raises req_i with we_i/addr_i/wdata_i and holds it
// until ack_o. The request is latched on the accepting edge; ack_o is a
// single-cycle pulse LATENCY edges later. In the ack cycle the requester either
// drops req_i or keeps it high with a fresh request, which is accepted on the
// next edge.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic [1:0]        dbg_state_o
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int OFFS_W = $clog2(WORD_BYTES);
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t state_q, state_d;
  logic   accept, commit;

  logic              we_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              bad_q;
  logic              bad_d;
  logic [IDX_W-1:0]  idx_d;

  logic [CNT_W-1:0]  cnt;
  logic              cnt_zero;

  logic [DATA_W-1:0] mem [DEPTH];

  assign idx_d = addr_i[IDX_W+OFFS_W-1:OFFS_W];

`ifdef DATA_MEMORY_RESPONDER_RANGE_CHECK_EN
  assign bad_d = (|addr_i[ADDR_W-1:IDX_W+OFFS_W]) | (|addr_i[OFFS_W-1:0]);
`else
  // High and byte-offset bits are deliberately ignored: addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[ADDR_W-1:IDX_W+OFFS_W], addr_i[OFFS_W-1:0]};
  assign bad_d = 1'b0;
`endif

  latency_counter #(.W(CNT_W)) u_latency_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (accept),
    .load_value (CNT_W'(LATENCY - 1)),
    .dec        ((state_q == WAIT) && !cnt_zero),
    .count      (cnt),
    .zero       (cnt_zero)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus the accept/commit strobes that drive the datapath.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          accept  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (req_i) begin
          accept  = 1'b1;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch; later changes on the request inputs are ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      bad_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= we_i;
      idx_q   <= idx_d;
      wdata_q <= wdata_i;
      bad_q   <= bad_d;
    end
  end

  // Store commit at the ack edge; a reset on that edge aborts the write.
  always_ff @(posedge clk_i) begin
    if (!rst_i && commit && we_q && !bad_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Registered outputs; rdata_o only changes on a load completion.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_o  <= 1'b0;
      ack_o   <= 1'b0;
      rdata_o <= '0;
      err_o   <= 1'b0;
    end else begin
      busy_o <= (state_d != IDLE);
      ack_o  <= commit;
      err_o  <= commit & bad_q;
      if (commit && !we_q) begin
        rdata_o <= bad_q ? '0 : mem[idx_q];
      end
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one LATENCY=10 instance and one
// LATENCY=1 instance sharing clock, reset and request payload.
module tb_data_memory_responder;

`ifdef DATA_MEMORY_RESPONDER_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam int LAT_A = 10;
  localparam int LAT_B = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, we;
  logic [31:0] addr, wdata;

  logic        busy_a, ack_a, err_a;
  logic [31:0] rdata_a;
  logic [1:0]  dbg_a;
  logic        busy_b, ack_b, err_b;
  logic [31:0] rdata_b;
  logic [1:0]  dbg_b;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  data_memory_responder #(.DEPTH(1024), .LATENCY(LAT_A), .ADDR_W(32), .DATA_W(32)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .busy_o(busy_a), .ack_o(ack_a), .rdata_o(rdata_a), .err_o(err_a), .dbg_state_o(dbg_a)
  );

  data_memory_responder #(.DEPTH(1024), .LATENCY(LAT_B), .ADDR_W(32), .DATA_W(32)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .busy_o(busy_b), .ack_o(ack_b), .rdata_o(rdata_b), .err_o(err_b), .dbg_state_o(dbg_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Starts at the accept edge; returns at the negedge where ack is seen.
  task automatic wait_ack(input bit sel, output int edges, output bit busy_ok);
    bit got;
    edges   = 0;
    got     = 0;
    busy_ok = 1;
    @(posedge clk);
    while (!got && edges < 100) begin
      @(negedge clk);
      if ((sel ? ack_b : ack_a) === 1'b1) begin
        got = 1;
      end else begin
        if ((sel ? busy_b : busy_a) !== 1'b1) busy_ok = 0;
        @(posedge clk);
        edges++;
      end
    end
  endtask

  // One complete request from an idle responder.
  task automatic txn(input bit sel, input logic we_v, input logic [31:0] a,
                     input logic [31:0] d, input int lat, input logic exp_err,
                     input string tag);
    int          edges;
    bit          busy_ok;
    logic [31:0] rd;
    logic        er;
    logic [31:0] exp_rd;
    @(negedge clk);
    we = we_v; addr = a; wdata = d;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    wait_ack(sel, edges, busy_ok);
    rd = sel ? rdata_b : rdata_a;
    er = sel ? err_b : err_a;
    req_a = 1'b0; req_b = 1'b0;
    check({tag, "_latency"}, edges, lat);
    check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
    if (!we_v) begin
      exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      check({tag, "_rdata"}, rd, exp_rd);
    end
    @(negedge clk);
    check({tag, "_ack_drop"}, {31'd0, sel ? ack_b : ack_a}, 32'd0);
    check({tag, "_idle"}, {31'd0, sel ? busy_b : busy_a}, 32'd0);
  endtask

  initial begin
    int          acks;
    int          edges;
    bit          busy_ok;
    logic [31:0] exp_rd;

    // Reset then idle.
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_ack", {31'd0, ack_a}, 32'd0);
    check("rst_rdata", rdata_a, 32'd0);
    check("rst_err", {31'd0, err_a}, 32'd0);
    check("rst_state", {30'd0, dbg_a}, 32'd0);
    check("rst_b_busy", {31'd0, busy_b}, 32'd0);
    rst = 1'b0;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack_a === 1'b1 || ack_b === 1'b1) acks++;
    end
    check("idle_no_ack", acks, 0);

    // Store then load.
    txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, LAT_A, 1'b0, "st10");
    check("rdata_hold_after_store", rdata_a, 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    txn(0, 1'b0, 32'h0000_0010, 32'h0, LAT_A, 1'b0, "ld10");

    // Wrap and ignored bits (flagged instead when range checking is built in).
    txn(0, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5, LAT_A, RC, "st1004");
    exp_q.push_back(RC ? 32'h0 : 32'hA5A5_A5A5);
    txn(0, 1'b0, 32'h0000_0007, 32'h0, LAT_A, RC, "ld7");

    // Back-to-back: store, then a load issued in the ack cycle.
    @(negedge clk);
    we = 1'b1; addr = 32'h0000_0040; wdata = 32'h1111_1111; req_a = 1'b1;
    wait_ack(0, edges, busy_ok);
    check("b2b_first_latency", edges, LAT_A);
    check("b2b_first_busy", {31'd0, busy_ok & busy_a}, 32'd1);
    we = 1'b0; wdata = 32'h0;
    exp_q.push_back(32'h1111_1111);
    wait_ack(0, edges, busy_ok);
    check("b2b_ack_gap", edges + 1, LAT_A + 1);
    check("b2b_busy_kept", {31'd0, busy_ok & busy_a}, 32'd1);
    exp_rd = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    check("b2b_rdata", rdata_a, exp_rd);
    req_a = 1'b0;
    @(negedge clk);
    check("b2b_idle", {31'd0, busy_a}, 32'd0);

    // Reset in the middle of a store.
    txn(0, 1'b1, 32'h0000_0020, 32'h0, LAT_A, 1'b0, "st20_zero");
    @(negedge clk);
    we = 1'b1; addr = 32'h0000_0020; wdata = 32'h1234_5678; req_a = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid_state_wait", {30'd0, dbg_a}, 32'd1);
    rst = 1'b1; req_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    check("mid_rst_ack", {31'd0, ack_a}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_a}, 32'd0);
    rst = 1'b0;
    acks = 0;
    repeat (15) begin
      @(negedge clk);
      if (ack_a === 1'b1) acks++;
    end
    check("mid_rst_no_ack", acks, 0);
    exp_q.push_back(32'h0);
    txn(0, 1'b0, 32'h0000_0020, 32'h0, LAT_A, 1'b0, "ld20");

    // Minimum latency instance, plus range flagging when built in.
    txn(1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, LAT_B, 1'b0, "b_st8");
    exp_q.push_back(RC ? 32'h0 : 32'hCAFE_F00D);
    txn(1, 1'b0, 32'h0000_1008, 32'h0, LAT_B, RC, "b_ld1008");
    exp_q.push_back(32'hCAFE_F00D);
    txn(1, 1'b0, 32'h0000_0008, 32'h0, LAT_B, 1'b0, "b_ld8");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
Multi-cycle data-memory responder that sits on the CPU's load/store port and services one request at a time. It uses a req/ack handshake with a programmable fixed latency. Word-addressed storage is held internally. The block is the memory-side end of the CPU data interface and replaces the single-cycle data memory for latency-tolerant pipeline and cache work.

Parameters:
DEPTH, 1024, number of 32-bit words stored; power of two, at least 2
LATENCY, 10, edges from request acceptance to the ack edge; at least 1
ADDR_W, 32, request address width
DATA_W, 32, data word width

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous, active-high reset
req_i  input  1  request valid; held high by the requester until ack_o
we_i  input  1  1 = store, 0 = load; sampled with req_i
addr_i  input  ADDR_W  byte address; bits [1:0] ignored
wdata_i  input  DATA_W  store data; sampled with req_i
busy_o  output  1  high while a request is in flight (WAIT or RESP)
ack_o  output  1  single-cycle completion pulse
rdata_o  output  DATA_W  load data; valid while ack_o is high for a load
err_o  output  1  range error flag (see Optional Feature)

Behaviour:
- Clock is clk_i. Reset rst_i is synchronous and active-high. Reset state: state=IDLE, busy_o=0, ack_o=0, rdata_o=0, err_o=0, counter=0. Memory array contents are not reset.
- Word index = addr_i[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- FSM states are IDLE, WAIT and RESP. Outputs are registered.
- IDLE: on an edge with req_i=1, latch we_i, index and wdata_i. Set counter=LATENCY-1, go to WAIT, busy_o=1.
- WAIT: while counter!=0, decrement it. On an edge with counter==0:
  - Store: write the latched data to mem[index].
  - Load: rdata_o <= mem[index].
  - Set ack_o=1 and go to RESP.
- Latency: accept edge E0 gives the ack_o-high cycle after edge E_LATENCY. With LATENCY=1, ack_o is high after E1.
- RESP: ack_o drops next edge.
  - If req_i=1 on that edge, treat it as a new request: latch it and go to WAIT. Back-to-back period is LATENCY+1 edges.
  - Otherwise go to IDLE and clear busy_o.
  - The requester must deassert req_i in the ack cycle unless it is issuing a new request.
- req_i, we_i, addr_i and wdata_i changes during WAIT are ignored, because the request is already latched.
- rdata_o holds its last load value after ack and is not updated by stores.
- Reset mid-operation (WAIT or RESP): abort immediately. No memory write, no ack, all outputs return to reset values.
- Load-after-store to the same address returns the stored value, since stores commit at their ack edge.

Optional Feature:
- Macro: DATA_MEMORY_RESPONDER_RANGE_CHECK_EN.
- Defined: a request whose addr_i[ADDR_W-1:log2(DEPTH)+2] is nonzero, or whose addr_i[1:0] is nonzero, is flagged. It still completes with normal latency, but:
  - Stores do not write.
  - Loads return rdata_o=0.
  - err_o=1 for exactly the ack cycle.
- Undefined: err_o is tied to 0 and addresses wrap as described above.

Decomposition:
- Shared package holds:
  - The FSM state typedef (IDLE, WAIT, RESP; 2-bit encoding).
  - Constants WORD_BYTES=4 and default DEPTH/LATENCY.
- One natural sub-module: latency_counter, a loadable down-counter with a zero flag. The array and FSM remain in the top.

Test Plan:
- Reset then idle: rst_i high 2 cycles -> busy_o=0, ack_o=0, rdata_o=0; no ack for 20 cycles with req_i=0.
- Store then load: store addr 0x0000_0010, data 0xDEAD_BEEF with LATENCY=10 -> ack_o high exactly 10 edges after accept. A following load of 0x10 -> rdata_o=0xDEAD_BEEF in its ack cycle.
- Wrap and ignored bits: with DEPTH=1024, store 0xA5A5_A5A5 at 0x0000_1004, then load 0x0000_0007 -> 0xA5A5_A5A5 (index 1).
- Back-to-back: req_i held high across the ack with a new store then a load -> second ack exactly LATENCY+1 edges after the first. busy_o stays high throughout.
- Reset mid-operation: store 0x1234_5678 to 0x20 (prior value 0x0), assert rst_i after 5 edges of WAIT -> no ack. A later load of 0x20 returns 0x0.
- LATENCY=1 plus range check (macro defined): load 0x0000_1000 -> ack after 1 edge, err_o=1, rdata_o=0. Aligned in-range load -> err_o=0.
